// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM responder with backdoor preload/inspect port.
// Define SPI_RESP_MODE_REG_EN to accept the RDMR (0x05) / WRMR (0x01) mode-register commands.
module spi_sram_responder #(
    parameter int unsigned ADDR_BITS   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 busy,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 5;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [7:0]  CMD_WRITE = 8'h02;
`ifdef SPI_RESP_MODE_REG_EN
    localparam logic [7:0]  CMD_RDMR  = 8'h05;
    localparam logic [7:0]  CMD_WRMR  = 8'h01;
    localparam logic [7:0]  MODE_SEQ  = 8'h40;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE,
        ST_RD_MR,
        ST_WR_MR
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s, vld_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [CNT_W-1:0]       bit_cnt;
    logic [6:0]             sin;
    logic [7:0]             sout;
    logic [ADDR_BITS-1:0]   addr;
    logic                   rd;

    logic [7:0]             in_byte;
    logic [ADDR_BITS-1:0]   addr_shift, addr_inc;
    logic                   byte_done, addr_done, spi_we;

    logic [7:0]             mem [DEPTH];

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign vld_s     = vld_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;
    assign cs_fall   = cs_prev & ~cs_s;

    assign in_byte    = {sin, mosi_s};
    assign addr_shift = {addr[ADDR_BITS-2:0], mosi_s};
    assign addr_inc   = addr + ADDR_BITS'(1);
    assign byte_done  = (bit_cnt == CNT_W'(7));
    assign addr_done  = (bit_cnt == CNT_W'(23));
    assign spi_we     = ~cs_s & (state == ST_WRITE) & sclk_rise & byte_done;

    assign busy     = ~cs_s;
    assign bd_rdata = mem[bd_addr];

    // Input synchronizers; cs_prev stays low until the chain holds real samples,
    // so a frame already in progress at reset release is not taken as a new one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            vld_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= vld_s & cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Frame sequencing
    always_comb begin
        state_d = state;
        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (sclk_rise && byte_done) begin
                        case (in_byte)
                            CMD_READ, CMD_WRITE: state_d = ST_ADDR;
`ifdef SPI_RESP_MODE_REG_EN
                            CMD_RDMR:            state_d = ST_RD_MR;
                            CMD_WRMR:            state_d = ST_WR_MR;
`endif
                            default:             state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise && addr_done) state_d = rd ? ST_READ : ST_WRITE;
                end
`ifdef SPI_RESP_MODE_REG_EN
                ST_WR_MR: begin
                    if (sclk_rise && byte_done) state_d = ST_IGNORE;
                end
`endif
                default: ;
            endcase
        end
    end

    // Shift registers, bit counter, address and miso
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso    <= 1'b0;
            bit_cnt <= '0;
            sin     <= '0;
            sout    <= '0;
            addr    <= '0;
            rd      <= 1'b0;
        end else if (cs_s) begin
            miso    <= 1'b0;
            bit_cnt <= '0;
            sin     <= '0;
            sout    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        sin <= in_byte[6:0];
                        if (byte_done) begin
                            bit_cnt <= '0;
                            rd      <= (in_byte == CMD_READ);
`ifdef SPI_RESP_MODE_REG_EN
                            sout    <= MODE_SEQ;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr <= addr_shift;
                        if (addr_done) begin
                            bit_cnt <= '0;
                            if (rd) sout <= mem[addr_shift];
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_READ: begin
                    // Next byte is fetched on the last falling edge so bytes run back to back.
                    if (sclk_fall) begin
                        miso <= sout[7];
                        if (byte_done) begin
                            sout    <= mem[addr_inc];
                            addr    <= addr_inc;
                            bit_cnt <= '0;
                        end else begin
                            sout    <= {sout[6:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise) begin
                        sin <= in_byte[6:0];
                        if (byte_done) begin
                            addr    <= addr_inc;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SPI_RESP_MODE_REG_EN
                ST_RD_MR: begin
                    if (sclk_fall) begin
                        miso <= sout[7];
                        if (byte_done) begin
                            sout    <= MODE_SEQ;
                            bit_cnt <= '0;
                        end else begin
                            sout    <= {sout[6:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WR_MR: begin
                    miso <= 1'b0;
                    if (sclk_rise) bit_cnt <= byte_done ? '0 : bit_cnt + CNT_W'(1);
                end
`endif
                default: begin
                    miso <= 1'b0;
                end
            endcase
        end
    end

    // Byte array; the backdoor write is ordered last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (spi_we) mem[addr] <= in_byte;
            if (bd_we)  mem[bd_addr] <= bd_wdata;
        end
    end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- Synthesizable SPI mode-0 slave that emulates a serial SRAM.
- It answers the CPU's SPI memory controller (sclk/mosi/cs/miso) and sits on the far end of one chip-select line.
- It is used on-chip as a small data scratchpad, or on the bench as the memory model for instruction and data fetches.
- A backdoor port preloads and inspects contents without SPI traffic.

Parameters:
- ADDR_BITS, default 6: byte array depth is 2^ADDR_BITS; only the low ADDR_BITS of the 24-bit SPI address are used.
- SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- sclk  input  1  SPI clock from the controller; asynchronous to clk.
- cs_n  input  1  active-low chip select.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- busy  output  1  high while synchronized cs_n is low.
- bd_we  input  1  backdoor write strobe.
- bd_addr  input  ADDR_BITS  backdoor address.
- bd_wdata  input  8  backdoor write data.
- bd_rdata  output  8  combinational read of mem[bd_addr].

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- On reset: miso=0, busy=0, state=IDLE, all shift registers and bit counters cleared, every memory byte cleared to 0x00.
- Synchronization:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on synchronized sclk (rise = prev 0, now 1).
  - sclk frequency must be <= clk/4.
- Timing:
  - mosi is sampled on the sclk rising edge, using the synchronized mosi captured on the same clk as the edge detect.
  - miso changes only on sclk falling edges, or on the clk after the cs_n low edge.
- Frame format, MSB first:
  - 8-bit command, then 24-bit address, then data bytes.
  - Data continues until cs_n rises; the address auto-increments after every data byte and wraps modulo 2^ADDR_BITS.
- State machine:
  - IDLE: on synchronized cs_n falling, go to CMD and clear the bit counter.
  - CMD: after the 8th rise, decode the command.
    - 0x03 (READ) goes to ADDR with rd=1.
    - 0x02 (WRITE) goes to ADDR with rd=0.
    - Any other command goes to IGNORE.
  - ADDR: shift 24 bits; the address register holds bits [ADDR_BITS-1:0].
    - After the 24th rise, go to READ or WRITE.
    - For READ, preload the shift-out register with mem[addr].
  - READ:
    - Every falling edge drives the next bit; the first falling edge after entering READ drives bit 7.
    - After the 8th falling edge of a byte, increment addr.
    - Load mem[addr+1] in time for the next byte's first falling edge, so there are no gap cycles between bytes.
  - WRITE:
    - Shift 8 bits in; on the 8th rise write mem[addr] in that clk, then increment addr.
    - A partial byte at cs_n rise is discarded.
  - IGNORE: miso=0; wait for cs_n high.
- Any state: synchronized cs_n high returns to IDLE on the next clk, miso=0, bit counters cleared. This is the mid-frame abort case.
- miso is 0 whenever the state is not READ. The output is never tristated.
- busy equals the inverted synchronized cs_n.
- Backdoor:
  - bd_we writes mem[bd_addr] on clk.
  - If an SPI write and a backdoor write hit the same address in the same clk, the backdoor wins.
  - If the addresses differ, both writes complete.
  - bd_rdata reflects writes from the following clk onward.
- rst_n low mid-frame forces IDLE and clears the memory. The controller's remaining sclk pulses are ignored until the next cs_n falling edge.

Optional Feature:
- Macro SPI_RESP_MODE_REG_EN.
- When defined:
  - Command 0x05 (RDMR) enters READ_MODE and returns 0x40 (sequential mode) repeatedly while cs_n stays low.
  - Command 0x01 (WRMR) accepts one byte, which is discarded; further bits go to IGNORE.
- When undefined: 0x05 and 0x01 are treated as unknown commands and go to IGNORE.

Test Plan:
- Backdoor preload mem[4..7]=0x93,0x00,0x50,0x00, then SPI READ 0x03 addr 0x000004 for 4 bytes -> miso bytes 0x93,0x00,0x50,0x00 with no gaps; busy high only while cs_n is low.
- SPI WRITE 0x02 addr 0x00003E, data 0xAA,0xBB,0xCC -> bd_rdata shows mem[0x3E]=0xAA, mem[0x3F]=0xBB, mem[0x00]=0xCC (wrap).
- WRITE addr 0x10, full byte 0x5A, then 5 bits of a second byte, then cs_n high -> mem[0x10]=0x5A, mem[0x11] unchanged; next READ from 0x10 works normally.
- Unknown command 0x9F with 40 sclk pulses -> miso stays 0, memory unchanged. With SPI_RESP_MODE_REG_EN, 0x05 -> miso returns 0x40.
- Same-clk SPI write to 0x08 (0x11) and bd_we at 0x08 (0x22) -> mem[0x08]=0x22.
- rst_n pulsed low during the data phase of a READ -> miso=0, busy=0, all mem=0x00; the next READ frame after reset returns 0x00.
